// File: rtl/uart_transmitter_pkg.sv
// rtl/uart_transmitter_pkg.sv - shared UART frame constants, baud timing and state encodings
package uart_transmitter_pkg;

    localparam int UART_FRAME_BITS = 10;

    typedef enum logic {
        UART_IDLE  = 1'b0,
        UART_SHIFT = 1'b1
    } uart_state_e;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // A one-cycle symbol still needs a one-bit counter.
    function automatic int baud_cnt_width(input int set);
        return (set > 1) ? $clog2(set) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte ingress handshake into the UART transmitter
interface uart_transmitter_if;

    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers for full/empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - FIFO-buffered 8N1 serialiser driving the UART TX line
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave in_if,
    output logic              serial_out,
    output logic              busy
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW               = baud_cnt_width(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] BAUD_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    uart_state_e                state_q, state_d;
    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]              baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                 fifo_head;

    assign in_if.data_in_ready = !fifo_full && !rst;
    assign fifo_push           = in_if.data_in_valid && in_if.data_in_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_if.data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The line is the shifter's LSB; idle keeps the shifter all ones.
    assign serial_out = shift_q[0];
    assign busy       = (state_q == UART_SHIFT) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UART_IDLE;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        fifo_pop = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = {1'b1, fifo_head, 1'b0};
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = UART_SHIFT;
                end
            end
            UART_SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        // End of stop bit: chain the next frame with no idle gap.
                        bit_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = {1'b1, fifo_head, 1'b0};
                        end else begin
                            shift_d = '1;
                            state_d = UART_IDLE;
                        end
                    end else begin
                        shift_d = {1'b1, shift_q[UART_FRAME_BITS-1:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit path of the Riscv151 UART. Accepts bytes from the CPU's memory-mapped I/O over a ready/valid handshake, buffers them in a small FIFO, and serialises each as an 8N1 frame on `FPGA_SERIAL_TX`. It is the transmit-side counterpart to the existing UART receiver and shares its baud timing.

## Interface
- `CLOCK_FREQ`, 50_000_000, core clock frequency in Hz.
- `BAUD_RATE`, 115_200, serial line rate in bits per second.
- `FIFO_DEPTH`, 4, number of bytes buffered ahead of the shifter. Must be a power of two and at least 2.
- `clk`  in  1  core clock. One clock domain only.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  8  byte to transmit.
- `data_in_valid`  in  1  `data_in` is presented this cycle.
- `data_in_ready`  out  1  the FIFO can accept a byte this cycle.
- `serial_out`  out  1  serial line, idles high.
- `busy`  out  1  a frame is being shifted or the FIFO is non-empty.

## Operation
- `SYMBOL_EDGE_TIME` = `CLOCK_FREQ / BAUD_RATE`, using integer division. Each serial bit is held for exactly this many cycles. With the defaults this is 434.
- Frame format: start bit (0), then data bits 0 through 7 (LSB first), then stop bit (1). A frame is 10 bits long.
- Handshake:
  - A byte is written into the FIFO on every rising edge where `data_in_valid & data_in_ready` holds.
  - `data_in_ready` = !fifo_full.
  - A write attempted while full is ignored, and the FIFO contents are unchanged.
- State machine:
  - **IDLE**: `serial_out` = 1. If the FIFO is not empty, pop the head byte into the 10-bit shift register `{1, byte, 0}`, clear the baud counter and bit counter, and go to SHIFT.
  - **SHIFT**: `serial_out` = shift[0]. The baud counter counts 0 to `SYMBOL_EDGE_TIME`-1. When it wraps, shift right, fill with 1, and increment the bit counter.
  - When the stop bit's period ends (bit counter reaches 9 and the baud counter wraps):
    - FIFO non-empty: pop the next byte and stay in SHIFT. Frames go back-to-back with no idle gap.
    - FIFO empty: go to IDLE.
- Simultaneous push and pop in the same cycle is legal. Occupancy is unchanged, and a full FIFO stays full, so ready stays low.
- `busy` = (state == SHIFT) | !fifo_empty.

## Timing
- Reset values: `serial_out` = 1, `busy` = 0, FIFO empty, state IDLE, all counters 0.
- `data_in_ready` is 0 while `rst` is high and 1 on the first cycle after reset is released.
- Reset in the middle of a frame aborts it. `serial_out` is 1 after that edge and all buffered bytes are discarded.
- Latency: a byte accepted at edge N into an empty FIFO with an idle shifter drives the start bit (`serial_out` = 0) from edge N+1.
- Frame duration: exactly 10 × `SYMBOL_EDGE_TIME` cycles, from the start-bit edge to the next start bit or return to idle.
- Each bit boundary lies exactly `SYMBOL_EDGE_TIME` cycles after the previous one, with no drift across frames.
- The FIFO read pointer advances only on a pop and the write pointer only on a push. Both wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer MSB.
- `serial_out` and `busy` come straight from registers, with no combinational path from `data_in_valid`.

## Structure
- Shared UART package/header holds:
  - `UART_FRAME_BITS` = 10.
  - The `SYMBOL_EDGE_TIME` derivation and counter width (`$clog2(SYMBOL_EDGE_TIME)`), so receiver and transmitter agree.
  - The IDLE/SHIFT state encodings.
- One sub-module, `sync_fifo` (parameters WIDTH and DEPTH, with push/pop/full/empty), instantiated with WIDTH=8 and DEPTH=`FIFO_DEPTH`. It is reusable for the receive side.

## Test plan
Benches override `CLOCK_FREQ`=1000 and `BAUD_RATE`=100, giving `SYMBOL_EDGE_TIME`=10.
- **Single byte**: push 0xA5 at edge N.
  - `serial_out` is 0 over cycles N+1 to N+10.
  - It then carries 1,0,1,0,0,1,0,1, each held for 10 cycles.
  - The stop bit is 1 for 10 cycles, then the line idles at 1 and `busy` falls at edge N+101.
- **Back-to-back**: push 0x00, 0xFF, 0x3C on consecutive cycles.
  - Three frames appear contiguously over 300 cycles, with no idle cycle between a stop bit and the next start bit.
  - The decoded bytes match in order.
- **Full/backpressure**: hold `data_in_valid` high with bytes 1 through 6 while the shifter is busy.
  - `data_in_ready` drops after the FIFO holds 4 bytes.
  - Unaccepted bytes never appear on the line.
  - Ready rises the cycle after each pop.
- **Push and pop together when full**: time a push on the pop edge. Occupancy stays at 4, ready stays 0, and no byte is lost or duplicated.
- **Reset mid-frame**: assert `rst` for 1 cycle during data bit 3 with 2 bytes queued.
  - `serial_out` is 1 after that edge, `busy` is 0 and `data_in_ready` is 1.
  - The line stays idle until a new push.
- **Wrap-around**: push and transmit 10 bytes (0x10 through 0x19) with `FIFO_DEPTH`=4. All 10 are received in order, exercising pointer wrap twice.
